// File: rtl/arr_port_arbiter.sv
// arr_port_arbiter: shares the single port of an arr_* memory (1-cycle read latency,
// registered read address) between NREQ round-robin kernel requesters and the host
// control port. The host port wins outright whenever controlArr=1.
//
// Optional feature: define ARR_ARB_LOCK_EN to add the lock[NREQ] input. A granted
// requester that holds both req and lock keeps the port until it drops either one.
module arr_port_arbiter #(
   parameter int unsigned NREQ  = 3,
   parameter int unsigned AW    = 10,
   parameter int unsigned DW    = 64,
   parameter int unsigned DEPTH = 1000
) (
   input  logic               clk,
   input  logic               r_enable,
   // host control port
   input  logic               controlArr,
   input  logic               controlArrWEnable,
   input  logic [AW-1:0]      controlArrAddr,
   input  logic [DW-1:0]      controlArrWData,
   output logic [DW-1:0]      controlArrRData,
   // kernel requesters
`ifdef ARR_ARB_LOCK_EN
   input  logic [NREQ-1:0]    lock,
`endif
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    reqWEnable,
   input  logic [NREQ*AW-1:0] reqAddr,
   input  logic [NREQ*DW-1:0] reqWData,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   // memory port
   output logic               arrWEnable,
   output logic [AW-1:0]      arrAddr,
   output logic [DW-1:0]      arrWData,
   input  logic [DW-1:0]      arrRData
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   // One extra bit so a DEPTH equal to 2**AW still compares correctly.
   localparam logic [AW:0] DepthLim = (AW+1)'(DEPTH);

   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0] rvalid_q, rvalid_d;
   logic            pend_oor_q, pend_oor_d;
`ifdef ARR_ARB_LOCK_EN
   logic            lock_q, lock_d;
`endif

   logic            arb_active;
   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   cand;
   logic            win_we;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_wdata;
   logic            win_oor;

   // Requesters only compete when neither reset nor the host owns the port.
   assign arb_active = !r_enable && !controlArr;

   // Winner select: first requester after rr_ptr, wrapping; a held lock overrides rotation.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = PW'((32'(rr_ptr_q) + k) % NREQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
`ifdef ARR_ARB_LOCK_EN
      if (lock_q && req[rr_ptr_q] && lock[rr_ptr_q]) begin
         win_found = 1'b1;
         win_idx   = rr_ptr_q;
      end
`endif
   end

   // Winner's request fields and its range check.
   always_comb begin
      win_we    = reqWEnable[win_idx];
      win_addr  = reqAddr[win_idx*AW +: AW];
      win_wdata = reqWData[win_idx*DW +: DW];
      win_oor   = ({1'b0, win_addr} >= DepthLim);
   end

   // One-hot grant, combinational in the cycle the access is presented.
   always_comb begin
      gnt = '0;
      if (arb_active && win_found) begin
         gnt[win_idx] = 1'b1;
      end
   end

   // Memory port drive: reset idles, host passes through, else the winner; idle is all zeros.
   always_comb begin
      arrWEnable = 1'b0;
      arrAddr    = '0;
      arrWData   = '0;
      if (r_enable) begin
         arrWEnable = 1'b0;
      end else if (controlArr) begin
         arrWEnable = controlArrWEnable;
         arrAddr    = controlArrAddr;
         arrWData   = controlArrWData;
      end else if (win_found) begin
         // Out-of-range writes are dropped; the grant still completes.
         arrWEnable = win_we && !win_oor;
         arrAddr    = win_addr;
         arrWData   = win_wdata;
      end
   end

   // Next state: pointer moves to the winner, reads schedule an rvalid for the next cycle.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      rvalid_d   = '0;
      pend_oor_d = 1'b0;
`ifdef ARR_ARB_LOCK_EN
      lock_d     = lock_q;
`endif
      if (arb_active && win_found) begin
         rr_ptr_d = win_idx;
         if (!win_we) begin
            rvalid_d[win_idx] = 1'b1;
            pend_oor_d        = win_oor;
         end
`ifdef ARR_ARB_LOCK_EN
         lock_d = lock[win_idx];
`endif
      end
`ifdef ARR_ARB_LOCK_EN
      else if (arb_active) begin
         // Nobody requesting: any lock is released. Host ownership leaves it untouched.
         lock_d = 1'b0;
      end
`endif
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (r_enable) begin
         rr_ptr_q   <= PW'(NREQ - 1);
         rvalid_q   <= '0;
         pend_oor_q <= 1'b0;
`ifdef ARR_ARB_LOCK_EN
         lock_q     <= 1'b0;
`endif
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         rvalid_q   <= rvalid_d;
         pend_oor_q <= pend_oor_d;
`ifdef ARR_ARB_LOCK_EN
         lock_q     <= lock_d;
`endif
      end
   end

   // Read return: a reset arriving in the return cycle squashes the pending rvalid.
   always_comb begin
      rvalid          = r_enable ? '0 : rvalid_q;
      rdata           = ((|rvalid) && !pend_oor_q) ? arrRData : '0;
      controlArrRData = controlArr ? arrRData : '0;
   end

endmodule

// File: tb/tb_arr_port_arbiter.sv
// Directed bench for arr_port_arbiter with a behavioural 1-cycle-latency memory model.
module tb_arr_port_arbiter;

   localparam int unsigned NREQ  = 3;
   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 64;
   localparam int unsigned DEPTH = 1000;

   logic               clk = 1'b0;
   logic               r_enable;
   logic               controlArr;
   logic               controlArrWEnable;
   logic [AW-1:0]      controlArrAddr;
   logic [DW-1:0]      controlArrWData;
   logic [DW-1:0]      controlArrRData;
   logic [NREQ-1:0]    lock;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    reqWEnable;
   logic [NREQ*AW-1:0] reqAddr;
   logic [NREQ*DW-1:0] reqWData;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;
   logic               arrWEnable;
   logic [AW-1:0]      arrAddr;
   logic [DW-1:0]      arrWData;
   logic [DW-1:0]      arrRData;

   logic [DW-1:0]      mem [0:1023];
   logic [AW-1:0]      mem_raddr;
   logic               load_en;
   logic [AW-1:0]      load_addr;
   logic [DW-1:0]      load_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   arr_port_arbiter #(
      .NREQ (NREQ),
      .AW   (AW),
      .DW   (DW),
      .DEPTH(DEPTH)
   ) dut (
      .clk              (clk),
      .r_enable         (r_enable),
      .controlArr       (controlArr),
      .controlArrWEnable(controlArrWEnable),
      .controlArrAddr   (controlArrAddr),
      .controlArrWData  (controlArrWData),
      .controlArrRData  (controlArrRData),
`ifdef ARR_ARB_LOCK_EN
      .lock             (lock),
`endif
      .req              (req),
      .reqWEnable       (reqWEnable),
      .reqAddr          (reqAddr),
      .reqWData         (reqWData),
      .gnt              (gnt),
      .rvalid           (rvalid),
      .rdata            (rdata),
      .arrWEnable       (arrWEnable),
      .arrAddr          (arrAddr),
      .arrWData         (arrWData),
      .arrRData         (arrRData)
   );

   // Memory model: registered read address, write at the edge, backdoor load port.
   always @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
      else if (arrWEnable) mem[arrAddr] <= arrWData;
      mem_raddr <= arrAddr;
   end
   assign arrRData = mem[mem_raddr];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int idx, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      reqWEnable[idx]       = we;
      reqAddr[idx*AW +: AW] = a;
      reqWData[idx*DW +: DW] = d;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      load_addr = a;
      load_data = d;
      load_en   = 1'b1;
      tick();
      load_en   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      r_enable          = 1'b1;
      controlArr        = 1'b0;
      controlArrWEnable = 1'b0;
      controlArrAddr    = '0;
      controlArrWData   = '0;
      lock              = '0;
      req               = '0;
      reqWEnable        = '0;
      reqAddr           = '0;
      reqWData          = '0;
      load_en           = 1'b0;
      load_addr         = '0;
      load_data         = '0;
      tick();
      preload(10'd0, 64'd0);
      preload(10'd10, 64'd100);
      preload(10'd11, 64'd111);
      preload(10'd12, 64'd122);
      preload(10'd20, 64'd200);
      preload(10'd30, 64'd300);
      preload(10'd1000, 64'd55);

      // Reset state: requests present but nothing granted, port idle.
      set_req(0, 1'b0, 10'd10, '0);
      set_req(1, 1'b0, 10'd11, '0);
      set_req(2, 1'b0, 10'd12, '0);
      req = 3'b111;
      #2;
      check_eq("rst_gnt", 64'(gnt), 64'd0);
      check_eq("rst_we", 64'(arrWEnable), 64'd0);
      check_eq("rst_addr", 64'(arrAddr), 64'd0);
      check_eq("rst_rvalid", 64'(rvalid), 64'd0);
      check_eq("rst_rdata", rdata, 64'd0);
      tick();

      // Round robin over three held reads.
      r_enable = 1'b0;
      #2;
      check_eq("rr0_gnt", 64'(gnt), 64'd1);
      check_eq("rr0_addr", 64'(arrAddr), 64'd10);
      tick(); #2;
      check_eq("rr1_gnt", 64'(gnt), 64'd2);
      check_eq("rr1_rvalid", 64'(rvalid), 64'd1);
      check_eq("rr1_rdata", rdata, 64'd100);
      tick(); #2;
      check_eq("rr2_gnt", 64'(gnt), 64'd4);
      check_eq("rr2_rvalid", 64'(rvalid), 64'd2);
      check_eq("rr2_rdata", rdata, 64'd111);
      tick(); #2;
      check_eq("rr3_gnt", 64'(gnt), 64'd1);
      check_eq("rr3_rvalid", 64'(rvalid), 64'd4);
      check_eq("rr3_rdata", rdata, 64'd122);
      tick();
      req = 3'b000;
      #2;
      check_eq("rr4_gnt", 64'(gnt), 64'd0);
      check_eq("rr4_idle_addr", 64'(arrAddr), 64'd0);
      check_eq("rr4_rvalid", 64'(rvalid), 64'd1);
      check_eq("rr4_rdata", rdata, 64'd100);
      tick(); #2;
      check_eq("rr5_rvalid", 64'(rvalid), 64'd0);
      check_eq("rr5_rdata", rdata, 64'd0);
      tick();

      // Write then read-after-write from another requester.
      set_req(0, 1'b1, 10'd5, 64'd42);
      req = 3'b001;
      #2;
      check_eq("wr_gnt", 64'(gnt), 64'd1);
      check_eq("wr_we", 64'(arrWEnable), 64'd1);
      check_eq("wr_addr", 64'(arrAddr), 64'd5);
      check_eq("wr_data", arrWData, 64'd42);
      tick();
      set_req(1, 1'b0, 10'd5, '0);
      req = 3'b010;
      #2;
      check_eq("raw_gnt", 64'(gnt), 64'd2);
      tick();
      req = 3'b000;
      #2;
      check_eq("raw_rvalid", 64'(rvalid), 64'd2);
      check_eq("raw_rdata", rdata, 64'd42);
      tick();

      // Host ownership for three cycles with requests pending.
      controlArr        = 1'b1;
      controlArrWEnable = 1'b1;
      controlArrAddr    = 10'd9;
      controlArrWData   = 64'd7;
      set_req(0, 1'b0, 10'd20, '0);
      set_req(1, 1'b0, 10'd21, '0);
      req = 3'b011;
      #2;
      check_eq("host0_gnt", 64'(gnt), 64'd0);
      check_eq("host0_we", 64'(arrWEnable), 64'd1);
      check_eq("host0_addr", 64'(arrAddr), 64'd9);
      check_eq("host0_data", arrWData, 64'd7);
      tick();
      controlArrWEnable = 1'b0;
      #2;
      check_eq("host1_gnt", 64'(gnt), 64'd0);
      check_eq("host1_we", 64'(arrWEnable), 64'd0);
      tick();
      controlArrAddr = 10'd0;
      #2;
      check_eq("host2_gnt", 64'(gnt), 64'd0);
      check_eq("host2_rdata", controlArrRData, 64'd7);
      check_eq("host2_rvalid", 64'(rvalid), 64'd0);
      tick();
      controlArr = 1'b0;
      #2;
      check_eq("resume_gnt", 64'(gnt), 64'd1);
      check_eq("resume_addr", 64'(arrAddr), 64'd20);
      check_eq("resume_hostrd", controlArrRData, 64'd0);
      tick();
      req = 3'b000;
      #2;
      check_eq("resume_rvalid", 64'(rvalid), 64'd1);
      check_eq("resume_rdata", rdata, 64'd200);
      tick();

      // Out-of-range write and read from requester 2.
      set_req(2, 1'b1, 10'd1000, '1);
      req = 3'b100;
      #2;
      check_eq("oorw_gnt", 64'(gnt), 64'd4);
      check_eq("oorw_we", 64'(arrWEnable), 64'd0);
      check_eq("oorw_addr", 64'(arrAddr), 64'd1000);
      tick();
      set_req(2, 1'b0, 10'd1000, '0);
      #2;
      check_eq("oorr_gnt", 64'(gnt), 64'd4);
      tick();
      req = 3'b000;
      #2;
      check_eq("oorr_rvalid", 64'(rvalid), 64'd4);
      check_eq("oorr_rdata", rdata, 64'd0);
      check_eq("oor_mem", mem[1000], 64'd55);
      tick();

      // Reset in the return cycle squashes rvalid and restores the pointer.
      set_req(1, 1'b0, 10'd11, '0);
      req = 3'b010;
      #2;
      check_eq("sq_gnt", 64'(gnt), 64'd2);
      tick();
      r_enable = 1'b1;
      req      = 3'b000;
      #2;
      check_eq("sq_rvalid1", 64'(rvalid), 64'd0);
      check_eq("sq_rdata1", rdata, 64'd0);
      tick();
      r_enable = 1'b0;
      set_req(0, 1'b0, 10'd30, '0);
      set_req(2, 1'b0, 10'd12, '0);
      req = 3'b111;
      #2;
      check_eq("sq_rvalid2", 64'(rvalid), 64'd0);
      check_eq("post_rst_gnt", 64'(gnt), 64'd1);
      check_eq("post_rst_addr", 64'(arrAddr), 64'd30);
      tick();

      // Read then write to the same address back to back: old data returned.
      set_req(1, 1'b1, 10'd30, 64'd999);
      req = 3'b010;
      #2;
      check_eq("b2b_gnt", 64'(gnt), 64'd2);
      check_eq("b2b_rvalid", 64'(rvalid), 64'd1);
      check_eq("b2b_rdata", rdata, 64'd300);
      tick();
      set_req(0, 1'b0, 10'd30, '0);
      req = 3'b001;
      #2;
      check_eq("b2b_wr_rvalid", 64'(rvalid), 64'd0);
      check_eq("b2b_rd_gnt", 64'(gnt), 64'd1);
      tick();
      req = 3'b000;
      #2;
      check_eq("b2b_new_rdata", rdata, 64'd999);
      tick();

`ifdef ARR_ARB_LOCK_EN
      // Requester 1 locks the port for four cycles, then rotation resumes.
      set_req(0, 1'b0, 10'd10, '0);
      set_req(1, 1'b0, 10'd11, '0);
      set_req(2, 1'b0, 10'd12, '0);
      req  = 3'b111;
      lock = 3'b010;
      for (int i = 0; i < 4; i++) begin
         #2;
         check_eq("lock_gnt", 64'(gnt), 64'd2);
         tick();
      end
      lock = 3'b000;
      #2;
      check_eq("unlock_gnt0", 64'(gnt), 64'd4);
      tick(); #2;
      check_eq("unlock_gnt1", 64'(gnt), 64'd1);
      tick();
      req = 3'b000;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
